// File: rtl/axi_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_adapter_pkg
// Description : Shared AXI B-response encodings and the response merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_adapter_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;

   // Severity order: EXOKAY lowest, so any plain OKAY beat downgrades an exclusive result.
   function automatic logic [1:0] bresp_rank(input logic [1:0] r);
      case (r)
         BRESP_DECERR: return 2'd3;
         BRESP_SLVERR: return 2'd2;
         BRESP_OKAY:   return 2'd1;
         default:      return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] bresp_merge(input logic [1:0] a, input logic [1:0] b,
                                              input logic mode);
      if (mode) return a | b;
      return (bresp_rank(a) >= bresp_rank(b)) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bresp_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bresp_id_fifo
// Description : Per-ID queue of outstanding sub-transaction counts.
// Revision    : 1.0 - initial release
// ============================================================================
module bresp_id_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic             aclk,
   input  logic             arst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign full      = (r_count == (PTR_W+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign head      = r_mem[r_rd_ptr];

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge aclk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/bresp_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bresp_merge_ctrl
// Description : Merges per-ID split B responses into one response per original write.
// Revision    : 1.0 - initial release
// ============================================================================
module bresp_merge_ctrl
   import axi_adapter_pkg::*;
#(
   parameter int ID_WIDTH  = 3,
   parameter int DEPTH     = 8,
   parameter int LEN_WIDTH = 3,
   parameter int RESP_MODE = 0
) (
   input  logic                 aclk,
   input  logic                 arst_n,
   input  logic                 push_valid,
   output logic                 push_ready,
   input  logic [ID_WIDTH-1:0]  push_id,
   input  logic [LEN_WIDTH-1:0] push_len,
   input  logic                 s_bvalid,
   output logic                 s_bready,
   input  logic [ID_WIDTH-1:0]  s_bid,
   input  logic [1:0]           s_bresp,
   output logic                 m_bvalid,
   input  logic                 m_bready,
   output logic [ID_WIDTH-1:0]  m_bid,
   output logic [1:0]           m_bresp,
   output logic                 err_unexpected
);

   localparam int   NUM_IDS  = 2**ID_WIDTH;
   localparam logic MODE_BIT = (RESP_MODE != 0);

   logic [NUM_IDS-1:0]   w_full;
   logic [NUM_IDS-1:0]   w_empty;
   logic [LEN_WIDTH-1:0] w_head [NUM_IDS];
   logic [LEN_WIDTH-1:0] r_rcv_cnt [NUM_IDS];
   logic [1:0]           r_acc [NUM_IDS];

   logic                 r_m_bvalid;
   logic [ID_WIDTH-1:0]  r_m_bid;
   logic [1:0]           r_m_bresp;
   logic                 r_err;

   logic                 w_push_fire;
   logic                 w_beat;
   logic                 w_hit;
   logic                 w_last;
   logic [1:0]           w_merged;

   assign push_ready  = !w_full[push_id];
   assign w_push_fire = push_valid && push_ready;
   assign s_bready    = !r_m_bvalid || m_bready;
   assign w_beat      = s_bvalid && s_bready;
   assign w_hit       = w_beat && !w_empty[s_bid];
   assign w_last      = w_hit && (r_rcv_cnt[s_bid] == w_head[s_bid]);

   // The first beat of a write seeds the accumulator; later beats fold into it.
   always_comb begin
      w_merged = s_bresp;
      if (r_rcv_cnt[s_bid] != '0)
         w_merged = bresp_merge(r_acc[s_bid], s_bresp, MODE_BIT);
   end

   generate
      for (genvar i = 0; i < NUM_IDS; i++) begin : g_id_fifo
         bresp_id_fifo #(
            .WIDTH (LEN_WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .aclk      (aclk),
            .arst_n    (arst_n),
            .push      (w_push_fire && (push_id == ID_WIDTH'(i))),
            .push_data (push_len),
            .pop       (w_last && (s_bid == ID_WIDTH'(i))),
            .head      (w_head[i]),
            .full      (w_full[i]),
            .empty     (w_empty[i])
         );
      end
   endgenerate

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_IDS; i++) begin
            r_rcv_cnt[i] <= '0;
            r_acc[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_IDS; i++) begin
            if (w_hit && (s_bid == ID_WIDTH'(i))) begin
               if (w_last) begin
                  r_rcv_cnt[i] <= '0;
                  r_acc[i]     <= '0;
               end else begin
                  r_rcv_cnt[i] <= r_rcv_cnt[i] + LEN_WIDTH'(1);
                  r_acc[i]     <= w_merged;
               end
            end
         end
      end
   end

   // Single-entry output slot; a completing beat may refill it in the cycle it drains.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_m_bvalid <= 1'b0;
         r_m_bid    <= '0;
         r_m_bresp  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_beat && w_empty[s_bid];
         if (w_last) begin
            r_m_bvalid <= 1'b1;
            r_m_bid    <= s_bid;
            r_m_bresp  <= w_merged;
         end else if (m_bready) begin
            r_m_bvalid <= 1'b0;
         end
      end
   end

   assign m_bvalid       = r_m_bvalid;
   assign m_bid          = r_m_bid;
   assign m_bresp        = r_m_bresp;
   assign err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bresp_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bresp_merge_ctrl
// Description : Directed self-checking bench for bresp_merge_ctrl (both merge modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bresp_merge_ctrl;

   logic       aclk = 1'b0;
   logic       arst_n = 1'b1;
   logic       push_valid = 1'b0;
   logic [2:0] push_id = '0;
   logic [2:0] push_len = '0;
   logic       s_bvalid = 1'b0;
   logic [2:0] s_bid = '0;
   logic [1:0] s_bresp = '0;
   logic       m_bready = 1'b1;

   logic       push_ready, s_bready, m_bvalid, err_unexpected;
   logic [2:0] m_bid;
   logic [1:0] m_bresp;
   logic       push_ready1, s_bready1, m_bvalid1, err_unexpected1;
   logic [2:0] m_bid1;
   logic [1:0] m_bresp1;

   int errors = 0;
   int checks = 0;

   always #5 aclk = ~aclk;

   bresp_merge_ctrl #(.ID_WIDTH(3), .DEPTH(8), .LEN_WIDTH(3), .RESP_MODE(0)) dut (
      .aclk(aclk), .arst_n(arst_n),
      .push_valid(push_valid), .push_ready(push_ready), .push_id(push_id), .push_len(push_len),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
      .err_unexpected(err_unexpected)
   );

   bresp_merge_ctrl #(.ID_WIDTH(3), .DEPTH(8), .LEN_WIDTH(3), .RESP_MODE(1)) dut_or (
      .aclk(aclk), .arst_n(arst_n),
      .push_valid(push_valid), .push_ready(push_ready1), .push_id(push_id), .push_len(push_len),
      .s_bvalid(s_bvalid), .s_bready(s_bready1), .s_bid(s_bid), .s_bresp(s_bresp),
      .m_bvalid(m_bvalid1), .m_bready(m_bready), .m_bid(m_bid1), .m_bresp(m_bresp1),
      .err_unexpected(err_unexpected1)
   );

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic push(input logic [2:0] id, input logic [2:0] len);
      push_valid = 1'b1; push_id = id; push_len = len;
      cyc();
      push_valid = 1'b0;
   endtask

   task automatic beat(input logic [2:0] id, input logic [1:0] resp);
      s_bvalid = 1'b1; s_bid = id; s_bresp = resp;
      cyc();
      s_bvalid = 1'b0;
   endtask

   task automatic test_reset();
      #3 arst_n = 1'b0;
      #2;
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", m_bvalid); end
      checks++; if (m_bid !== 3'd0) begin errors++; $display("FAIL rst_bid got %0d want 0", m_bid); end
      checks++; if (m_bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", m_bresp); end
      checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_unexpected); end
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_push_ready got %b want 1", push_ready); end
      checks++; if (s_bready !== 1'b1) begin errors++; $display("FAIL rst_s_bready got %b want 1", s_bready); end
      @(negedge aclk);
      arst_n = 1'b1;
      cyc();
   endtask

   task automatic test_merge_priority();
      push(3'd2, 3'd3);
      beat(3'd2, 2'b00);
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b want 0", m_bvalid); end
      beat(3'd2, 2'b00);
      beat(3'd2, 2'b10);
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL t1_third_valid got %b want 0", m_bvalid); end
      beat(3'd2, 2'b00);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd2 || m_bresp !== 2'b10)
         begin errors++; $display("FAIL t1_merged got v%b id%0d r%b want v1 id2 r10", m_bvalid, m_bid, m_bresp); end
      cyc();
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL t1_drain got %b want 0", m_bvalid); end
   endtask

   task automatic test_interleave();
      push(3'd1, 3'd1);
      push(3'd5, 3'd0);
      beat(3'd1, 2'b01);
      beat(3'd5, 2'b00);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd5 || m_bresp !== 2'b00)
         begin errors++; $display("FAIL t2_id5 got v%b id%0d r%b want v1 id5 r00", m_bvalid, m_bid, m_bresp); end
      beat(3'd1, 2'b01);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd1 || m_bresp !== 2'b01)
         begin errors++; $display("FAIL t2_id1_ex got v%b id%0d r%b want v1 id1 r01", m_bvalid, m_bid, m_bresp); end
      push(3'd1, 3'd1);
      beat(3'd1, 2'b01);
      beat(3'd1, 2'b00);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd1 || m_bresp !== 2'b00)
         begin errors++; $display("FAIL t2_id1_ok got v%b id%0d r%b want v1 id1 r00", m_bvalid, m_bid, m_bresp); end
      cyc();
   endtask

   task automatic test_full();
      int got;
      for (int i = 0; i < 8; i++) push(3'd0, 3'd0);
      push_id = 3'd0; #1;
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready got %b want 0", push_ready); end
      push_id = 3'd3; #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL t3_other_ready got %b want 1", push_ready); end
      push(3'd3, 3'd0);
      // push to the full id0 queue in the same cycle as its head pops
      push_valid = 1'b1; push_id = 3'd0; push_len = 3'd0;
      s_bvalid = 1'b1; s_bid = 3'd0; s_bresp = 2'b01;
      #1;
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL t3_pop_push_ready got %b want 0", push_ready); end
      cyc();
      push_valid = 1'b0; s_bvalid = 1'b0;
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd0 || m_bresp !== 2'b01)
         begin errors++; $display("FAIL t3_pop got v%b id%0d r%b want v1 id0 r01", m_bvalid, m_bid, m_bresp); end
      push_id = 3'd0; #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL t3_after_pop_ready got %b want 1", push_ready); end
      beat(3'd3, 2'b10);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd3 || m_bresp !== 2'b10)
         begin errors++; $display("FAIL t3_id3 got v%b id%0d r%b want v1 id3 r10", m_bvalid, m_bid, m_bresp); end
      got = 0;
      for (int i = 0; i < 7; i++) begin
         beat(3'd0, 2'b00);
         if (m_bvalid === 1'b1 && m_bid === 3'd0) got++;
      end
      checks++; if (got !== 7) begin errors++; $display("FAIL t3_drain_count got %0d want 7", got); end
      beat(3'd0, 2'b00);
      checks++; if (err_unexpected !== 1'b1 || m_bvalid !== 1'b0)
         begin errors++; $display("FAIL t3_rejected_push got err%b v%b want err1 v0", err_unexpected, m_bvalid); end
      cyc();
   endtask

   task automatic test_backpressure();
      push(3'd7, 3'd0);
      push(3'd3, 3'd0);
      m_bready = 1'b0;
      beat(3'd7, 2'b10);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd7 || m_bresp !== 2'b10)
         begin errors++; $display("FAIL t4_first got v%b id%0d r%b want v1 id7 r10", m_bvalid, m_bid, m_bresp); end
      checks++; if (s_bready !== 1'b0) begin errors++; $display("FAIL t4_s_bready got %b want 0", s_bready); end
      s_bvalid = 1'b1; s_bid = 3'd3; s_bresp = 2'b11;
      cyc(); cyc(); cyc();
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd7 || m_bresp !== 2'b10)
         begin errors++; $display("FAIL t4_hold got v%b id%0d r%b want v1 id7 r10", m_bvalid, m_bid, m_bresp); end
      m_bready = 1'b1; #1;
      checks++; if (s_bready !== 1'b1) begin errors++; $display("FAIL t4_release got %b want 1", s_bready); end
      cyc();
      s_bvalid = 1'b0;
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd3 || m_bresp !== 2'b11)
         begin errors++; $display("FAIL t4_second got v%b id%0d r%b want v1 id3 r11", m_bvalid, m_bid, m_bresp); end
      cyc();
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL t4_drain got %b want 0", m_bvalid); end
   endtask

   task automatic test_unexpected();
      push(3'd1, 3'd1);
      beat(3'd6, 2'b11);
      checks++; if (err_unexpected !== 1'b1 || m_bvalid !== 1'b0)
         begin errors++; $display("FAIL t5_err got err%b v%b want err1 v0", err_unexpected, m_bvalid); end
      cyc();
      checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL t5_pulse got %b want 0", err_unexpected); end
      beat(3'd1, 2'b00);
      checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL t5_id1_early got %b want 0", m_bvalid); end
      beat(3'd1, 2'b00);
      checks++; if (m_bvalid !== 1'b1 || m_bid !== 3'd1 || m_bresp !== 2'b00)
         begin errors++; $display("FAIL t5_id1 got v%b id%0d r%b want v1 id1 r00", m_bvalid, m_bid, m_bresp); end
      cyc();
   endtask

   task automatic test_or_mode_and_reset();
      push(3'd4, 3'd1);
      beat(3'd4, 2'b10);
      beat(3'd4, 2'b01);
      checks++; if (m_bvalid1 !== 1'b1 || m_bid1 !== 3'd4 || m_bresp1 !== 2'b11)
         begin errors++; $display("FAIL t6_or got v%b id%0d r%b want v1 id4 r11", m_bvalid1, m_bid1, m_bresp1); end
      checks++; if (m_bresp !== 2'b10) begin errors++; $display("FAIL t6_prio got %b want 10", m_bresp); end
      cyc();
      push(3'd4, 3'd3);
      push(3'd2, 3'd0);
      beat(3'd4, 2'b00);
      beat(3'd4, 2'b00);
      m_bready = 1'b0;
      beat(3'd2, 2'b10);
      checks++; if (m_bvalid1 !== 1'b1 || m_bid1 !== 3'd2)
         begin errors++; $display("FAIL t6_pre_rst got v%b id%0d want v1 id2", m_bvalid1, m_bid1); end
      arst_n = 1'b0;
      #1;
      checks++; if (m_bvalid1 !== 1'b0 || m_bid1 !== 3'd0 || m_bresp1 !== 2'b00)
         begin errors++; $display("FAIL t6_async_rst got v%b id%0d r%b want v0 id0 r00", m_bvalid1, m_bid1, m_bresp1); end
      checks++; if (s_bready1 !== 1'b1 || push_ready1 !== 1'b1)
         begin errors++; $display("FAIL t6_rst_ready got s%b p%b want s1 p1", s_bready1, push_ready1); end
      #2 arst_n = 1'b1;
      m_bready = 1'b1;
      cyc();
      beat(3'd4, 2'b00);
      checks++; if (err_unexpected1 !== 1'b1 || m_bvalid1 !== 1'b0)
         begin errors++; $display("FAIL t6_after_rst got err%b v%b want err1 v0", err_unexpected1, m_bvalid1); end
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_merge_priority();
      test_interleave();
      test_full();
      test_backpressure();
      test_unexpected();
      test_or_mode_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
